// File: rtl/dpe_pkg.sv
// Shared definitions for the DPE accumulator slice: default widths, the
// accumulator state enum and a width-generic saturating add.
package dpe_pkg;

  localparam int unsigned DATAW_DEF = 32;
  localparam int unsigned ACCW_DEF  = 32;
  localparam int unsigned LENW_DEF  = 8;

  // Widest accumulator the saturating add supports (ACCW must be <= SAT_MAXW-1).
  localparam int unsigned SAT_MAXW  = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Adds two sign-extended operands one bit wider than needed and clamps the
  // result to the signed range of a w-bit accumulator.
  function automatic logic signed [SAT_MAXW-1:0] sat_add(
    input logic signed [SAT_MAXW-1:0] a,
    input logic signed [SAT_MAXW-1:0] b,
    input int unsigned                w
  );
    logic signed [SAT_MAXW:0] one;
    logic signed [SAT_MAXW:0] hi;
    logic signed [SAT_MAXW:0] lo;
    logic signed [SAT_MAXW:0] sum;
    one = (SAT_MAXW+1)'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    sum = (SAT_MAXW+1)'(a) + (SAT_MAXW+1)'(b);
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return SAT_MAXW'(sum);
  endfunction

endpackage

// File: rtl/dpe_accum_if.sv
// Data-path bundle of the DPE accumulator.
//   i_data/i_valid : partial dot products from the DPE chain (not stallable)
//   o_data/o_valid : head of the result FIFO
//   i_ready        : downstream accepts o_data
// slave is the accumulator's view, master the upstream/downstream side.
interface dpe_accum_if
  import dpe_pkg::*;
#(
  parameter int unsigned BATCH = 1,
  parameter int unsigned DATAW = DATAW_DEF,
  parameter int unsigned ACCW  = ACCW_DEF
);

  logic [BATCH-1:0][DATAW-1:0] i_data;
  logic                        i_valid;
  logic [BATCH-1:0][ACCW-1:0]  o_data;
  logic                        o_valid;
  logic                        i_ready;

  modport master (
    output i_data, i_valid, i_ready,
    input  o_data, o_valid
  );

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_data, o_valid
  );

endinterface

// File: rtl/acc_fifo.sv
// Synchronous first-word-fall-through FIFO for accumulated result vectors.
//   push/wdata        : write request (accepted when not full, or full with pop)
//   pop               : read request (ignored when empty)
//   rdata             : head entry, valid whenever empty==0
//   count             : current occupancy
//   full/empty        : registered occupancy flags
//   almost_full       : registered, set when free entries <= AF_MARGIN
module acc_fifo #(
  parameter  int unsigned W         = 64,
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned AF_MARGIN = 8,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          full_q;
  logic          empty_q;
  logic          af_q;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full_q || do_pop);

  // Next-state occupancy; flags are registered from it.
  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Storage, pointers and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_q] <= wdata;
        wr_ptr_q      <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
      af_q    <= (cnt_d >= CW'(DEPTH - AF_MARGIN));
    end
  end

  assign rdata       = mem[rd_ptr_q];
  assign count       = cnt_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;

endmodule

// File: rtl/dpe_accum.sv
// Per-lane accumulator of chunked DPE partial dot products.
//   clk, rst        : clock, synchronous active-high reset
//   i_cfg_len/valid : chunks per reduction (0 means 1), taken only when idle
//                     and no data is arriving
//   bus (slave)     : partial-product input and result FIFO output
//   o_almost_full   : upstream must stop issuing DPE compute vectors
//   o_busy          : a reduction is in progress
//   o_err           : sticky, a finished result was dropped on a full FIFO
module dpe_accum
  import dpe_pkg::*;
#(
  parameter int unsigned DATAW      = DATAW_DEF,
  parameter int unsigned ACCW       = ACCW_DEF,
  parameter int unsigned BATCH      = 1,
  parameter int unsigned LENW       = LENW_DEF,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_MARGIN  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LENW-1:0] i_cfg_len,
  input  logic            i_cfg_valid,
  dpe_accum_if.slave      bus,
  output logic            o_almost_full,
  output logic            o_busy,
  output logic            o_err
);

  localparam int unsigned VECW = BATCH * ACCW;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

  state_e                     state_q;
  state_e                     state_d;
  logic [LENW-1:0]            cnt_q;
  logic [LENW-1:0]            cnt_d;
  logic [LENW-1:0]            cnt_inc;
  logic [LENW-1:0]            len_q;
  logic [LENW-1:0]            len_d;
  logic [BATCH-1:0][ACCW-1:0] acc_q;
  logic [BATCH-1:0][ACCW-1:0] acc_d;
  logic                       emit_q;
  logic                       emit_d;
  logic                       err_q;

  logic [VECW-1:0]            fifo_rdata;
  logic [CW-1:0]              fifo_count;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_af;
  logic                       pop_acc;
  logic                       drop;

  // State register and reduction datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= LENW'(1);
      acc_q   <= '0;
      emit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      emit_q  <= emit_d;
      err_q   <= err_q | drop;
    end
  end

  // Next state, chunk counting and per-lane accumulation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    acc_d   = acc_q;
    emit_d  = 1'b0;
    cnt_inc = cnt_q + LENW'(1);

    if (i_cfg_valid && (state_q == IDLE) && !bus.i_valid) begin
      len_d = (i_cfg_len == '0) ? LENW'(1) : i_cfg_len;
    end

    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          for (int unsigned b = 0; b < BATCH; b++) begin
            acc_d[b] = ACCW'($signed(bus.i_data[b]));
          end
          if (len_q == LENW'(1)) begin
            emit_d = 1'b1;
          end else begin
            cnt_d   = LENW'(1);
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (bus.i_valid) begin
          for (int unsigned b = 0; b < BATCH; b++) begin
            acc_d[b] = ACCW'(sat_add(SAT_MAXW'($signed(acc_q[b])),
                                     SAT_MAXW'($signed(bus.i_data[b])),
                                     ACCW));
          end
          if (cnt_inc == len_q) begin
            emit_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A finished sum is lost only when the FIFO is full and nothing leaves.
  assign pop_acc = bus.i_ready && (fifo_count != '0);
  assign drop    = emit_q && fifo_full && !pop_acc;

  acc_fifo #(
    .W         (VECW),
    .DEPTH     (FIFO_DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (emit_q),
    .wdata       (acc_q),
    .pop         (bus.i_ready),
    .rdata       (fifo_rdata),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (fifo_af)
  );

  assign bus.o_data    = fifo_rdata;
  assign bus.o_valid   = !fifo_empty;
  assign o_almost_full = fifo_af;
  assign o_busy        = (state_q == ACCUM);
  assign o_err         = err_q;

endmodule

// File: tb/tb_dpe_accum.sv
// Bench for dpe_accum with BATCH=2, DATAW=ACCW=32, FIFO_DEPTH=16, AF_MARGIN=8.
// The reference keeps each reduction as a list of chunks and a queue of
// finished sums; outputs are compared every cycle on the falling edge.
module tb_dpe_accum;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFM   = 8;

  typedef logic [63:0] vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_len;
  logic       cfg_valid;
  logic       o_af;
  logic       o_busy;
  logic       o_err;

  dpe_accum_if #(.BATCH(2), .DATAW(32), .ACCW(32)) bus ();

  dpe_accum #(
    .DATAW      (32),
    .ACCW       (32),
    .BATCH      (2),
    .LENW       (8),
    .FIFO_DEPTH (DEPTH),
    .AF_MARGIN  (AFM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cfg_len     (cfg_len),
    .i_cfg_valid   (cfg_valid),
    .bus           (bus),
    .o_almost_full (o_af),
    .o_busy        (o_busy),
    .o_err         (o_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state.
  vec_t mq[$];
  vec_t chunks[$];
  int   m_len = 1;
  bit   m_pend = 1'b0;
  vec_t m_pend_vec = '0;
  bit   m_err = 1'b0;
  bit   m_af = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int l0, input int l1);
    return {l1, l0};
  endfunction

  function automatic longint clamp32(input longint s);
    if (s > 64'sd2147483647) return 64'sd2147483647;
    if (s < -64'sd2147483648) return -64'sd2147483648;
    return s;
  endfunction

  // Sum of the collected chunks, clamped after every addition, per lane.
  function automatic vec_t reduce_chunks();
    vec_t   r;
    longint s;
    logic [31:0] w;
    r = '0;
    for (int b = 0; b < 2; b++) begin
      w = chunks[0][32*b +: 32];
      s = longint'($signed(w));
      for (int i = 1; i < chunks.size(); i++) begin
        w = chunks[i][32*b +: 32];
        s = clamp32(s + longint'($signed(w)));
      end
      r[32*b +: 32] = 32'(s);
    end
    return r;
  endfunction

  task automatic model_step();
    int sz;
    bit popping;
    if (rst) begin
      mq.delete();
      chunks.delete();
      m_len  = 1;
      m_pend = 1'b0;
      m_err  = 1'b0;
      m_af   = 1'b0;
      return;
    end
    sz      = mq.size();
    popping = bus.i_ready && (sz > 0);
    if (popping) void'(mq.pop_front());
    if (m_pend) begin
      if (sz < DEPTH || popping) mq.push_back(m_pend_vec);
      else m_err = 1'b1;
    end
    m_af   = (mq.size() >= DEPTH - AFM);
    m_pend = 1'b0;
    if (cfg_valid && chunks.size() == 0 && !bus.i_valid)
      m_len = (cfg_len == 8'd0) ? 1 : int'(cfg_len);
    if (bus.i_valid) begin
      chunks.push_back(bus.i_data);
      if (chunks.size() == m_len) begin
        m_pend_vec = reduce_chunks();
        m_pend     = 1'b1;
        chunks.delete();
      end
    end
  endtask

  task automatic check_outputs();
    check("o_valid", 64'(bus.o_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) check("o_data", bus.o_data, mq[0]);
    check("o_busy", 64'(o_busy), 64'(chunks.size() != 0));
    check("o_almost_full", 64'(o_af), 64'(m_af));
    check("o_err", 64'(o_err), 64'(m_err));
  endtask

  // Drive one cycle of inputs, advance the reference at the edge, compare.
  task automatic cycle(input bit v, input vec_t d, input bit rdy,
                       input bit cv = 1'b0, input logic [7:0] cl = 8'd0,
                       input bit r = 1'b0);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_ready = rdy;
    cfg_valid   = cv;
    cfg_len     = cl;
    rst         = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   drained;
    int   ready_pct;
    vec_t d;

    // Reset state.
    cycle(0, '0, 0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0, 1);
    check("rst_o_data", bus.o_data, 64'd0);

    // len=3 reduction and two-edge latency.
    cycle(0, '0, 0, 1, 8'd3);
    cycle(1, mk(10, -1), 0);
    cycle(1, mk(20, -2), 0);
    check("s1_busy", 64'(o_busy), 64'd1);
    cycle(1, mk(30, -3), 0);
    check("s1_valid_early", 64'(bus.o_valid), 64'd0);
    cycle(0, '0, 0);
    check("s1_valid", 64'(bus.o_valid), 64'd1);
    check("s1_sum", bus.o_data, mk(60, -6));
    cycle(0, '0, 1);

    // len=1 back-to-back streaming.
    cycle(0, '0, 1, 1, 8'd1);
    for (int i = 1; i <= 5; i++) cycle(1, mk(i, i + 100), 1);
    cycle(0, '0, 1);
    cycle(0, '0, 1);

    // Saturation at both ends (lane 0 positive, lane 1 negative).
    cycle(0, '0, 0, 1, 8'd2);
    cycle(1, mk(32'h7FFFFFF0, 32'h80000010), 0);
    cycle(1, mk(32'h00000100, -256), 0);
    cycle(0, '0, 0);
    check("sat_both", bus.o_data, mk(32'h7FFFFFFF, 32'h80000000));
    cycle(0, '0, 1);

    // Fill to overflow, then drain.
    cycle(0, '0, 0, 1, 8'd1);
    for (int i = 0; i < 17; i++) cycle(1, mk(3 * i + 1, -i), 0);
    cycle(0, '0, 0);
    check("ovf_err", 64'(o_err), 64'd1);
    check("ovf_af", 64'(o_af), 64'd1);
    drained = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_valid) begin
        check("drain_data", bus.o_data, mk(3 * drained + 1, -drained));
        drained++;
      end
      cycle(0, '0, 1);
    end
    check("drain_count", 64'(drained), 64'd16);

    // Config ignored mid-reduction, honoured when idle.
    cycle(0, '0, 0, 1, 8'd2);
    cycle(1, mk(1, 2), 0);
    cycle(0, '0, 0, 1, 8'd4);
    cycle(1, mk(3, 4), 0);
    cycle(0, '0, 0);
    check("cfg_ignored_valid", 64'(bus.o_valid), 64'd1);
    check("cfg_ignored_sum", bus.o_data, mk(4, 6));
    cycle(0, '0, 1);
    cycle(0, '0, 0, 1, 8'd4);
    for (int i = 0; i < 3; i++) cycle(1, mk(1, 2), 0);
    cycle(0, '0, 0);
    check("cfg_len4_pending", 64'(bus.o_valid), 64'd0);
    cycle(1, mk(1, 2), 0);
    cycle(0, '0, 0);
    check("cfg_len4_sum", bus.o_data, mk(4, 8));
    cycle(0, '0, 1);

    // Reset with a partial sum and three queued results.
    cycle(0, '0, 0, 1, 8'd1);
    for (int i = 0; i < 3; i++) cycle(1, mk(i, i), 0);
    cycle(0, '0, 0, 1, 8'd2);
    cycle(1, mk(9, 9), 0);
    cycle(0, '0, 0, 0, 8'd0, 1);
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    cycle(1, mk(7, -7), 0);
    cycle(0, '0, 0);
    check("post_rst_sum", bus.o_data, mk(7, -7));
    cycle(0, '0, 1);

    // Randomized traffic with varying backpressure.
    ready_pct = 90;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) ready_pct = ($urandom_range(0, 1) == 0) ? 25 : 90;
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 3) == 0) d[32*b +: 32] = $urandom();
        else d[32*b +: 32] = 32'($urandom_range(0, 2000)) - 32'd1000;
      end
      cycle($urandom_range(0, 9) < 7, d,
            $urandom_range(0, 99) < ready_pct,
            $urandom_range(0, 7) == 0, 8'($urandom_range(0, 5)),
            $urandom_range(0, 499) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
